ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_pkg
//  Description : Shared types and constants for the PS/2 host transmitter
//                (state encoding, default timing, frame geometry).
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_REQ       = 3'd3,
        ST_DATA      = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } state_t;

    // ~100 us clock inhibit and ~15 ms inter-edge limit at 28.6 MHz
    localparam int unsigned C_DEF_INHIBIT_CYCLES = 2900;
    localparam int unsigned C_DEF_TIMEOUT_CYCLES = 430000;

    // start + 8 data + parity + stop, followed by the device ACK clock
    localparam int unsigned C_FRAME_BITS = 11;

    // PS/2 uses odd parity over the data byte
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync
//  Description : Two-flop synchronizer for a raw PS/2 line with falling-edge
//                detection. Idles high (PS/2 lines are pulled up).
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one history flop; all reset to the idle-high level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Inhibits the bus,
//                issues request-to-send, shifts out data/parity/stop on the
//                device clock and checks the device ACK, with an inter-edge
//                timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = C_DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned C_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned C_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Counters run 0..N-1, so the last value always fits in $clog2(N) bits
    localparam logic [C_INH_W-1:0] C_INH_LAST = C_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);

    // Edge 9 carries parity; the edge after it (stop) releases the data line
    localparam logic [3:0] C_LAST_DRIVEN_EDGE = 4'(C_FRAME_BITS - 2);

    state_t               state_q, state_d;
    logic [C_INH_W-1:0]   inh_q, inh_d;
    logic [C_TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]           edge_q, edge_d;
    logic [8:0]           frame_q, frame_d;   // {parity, data}
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 dat_oe_q, dat_oe_d;

    logic                 w_clk_sync;
    logic                 w_clk_fall;
    logic                 w_dat_sync;
    logic                 w_unused_dat_fall;
    logic                 w_active;
    logic                 w_timeout;
    logic [3:0]           w_bit_idx;

    ps2_sync u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (ps2clk_in),
        .sync_o  (w_clk_sync),
        .fall_o  (w_clk_fall)
    );

    ps2_sync u_dat_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (ps2dat_in),
        .sync_o  (w_dat_sync),
        .fall_o  (w_unused_dat_fall)
    );

    // Device clock edges only matter once the bus has been handed to the device
    assign w_active  = (state_q == ST_REQ)  || (state_q == ST_DATA) ||
                       (state_q == ST_ACK)  || (state_q == ST_WAIT_IDLE);
    assign w_timeout = w_active && (tmo_q == C_TMO_LAST);

    // Next-state, counters and completion pulses
    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        edge_d  = edge_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = '0;
        if (w_active && !w_clk_fall) begin
            tmo_d = tmo_q + C_TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                inh_d  = '0;
                edge_d = '0;
                if (tx_start) begin
                    frame_d = {odd_parity(tx_data), tx_data};
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == C_INH_LAST) begin
                    inh_d   = '0;
                    state_d = ST_START;
                end else begin
                    inh_d = inh_q + C_INH_W'(1);
                end
            end
            ST_START: begin
                edge_d  = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (w_clk_fall) begin
                    edge_d  = 4'd1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_clk_fall) begin
                    edge_d = edge_q + 4'd1;
                    if (edge_q == C_LAST_DRIVEN_EDGE) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    edge_d = edge_q + 4'd1;
                    if (w_dat_sync) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_sync && w_dat_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled device overrides everything, so done and error never coincide
        if (w_timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end
    end

    // After edge k the host presents frame bit k-1 (data LSB first, then parity)
    assign w_bit_idx = edge_d - 4'd1;

    // Line drive derived from the next state so the pins are glitch-free flops
    always_comb begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        case (state_d)
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
            end
            ST_START: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b1;
            end
            ST_REQ: begin
                dat_oe_d = 1'b1;
            end
            ST_DATA: begin
                dat_oe_d = ~frame_d[w_bit_idx];
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers; reset releases both lines immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            inh_q    <= '0;
            tmo_q    <= '0;
            edge_q   <= '0;
            frame_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            inh_q    <= inh_d;
            tmo_q    <= tmo_d;
            edge_q   <= edge_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign ps2clk_oe = clk_oe_q;
    assign ps2dat_oe = dat_oe_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with an open-drain PS/2
//                keyboard model (scaled timing).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 600;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2clk_oe, ps2dat_oe, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2clk_line, ps2dat_line;

    // Wired-AND open-drain bus with pull-ups
    assign ps2clk_line = ~(ps2clk_oe | dev_clk_low);
    assign ps2dat_line = ~(ps2dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2clk_in (ps2clk_line),
        .ps2dat_in (ps2dat_line),
        .ps2clk_oe (ps2clk_oe),
        .ps2dat_oe (ps2dat_oe),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   n_done = 0, n_err = 0, n_both = 0, n_inh = 0, n_start = 0;
    logic last_busy = 1'b0;

    // Running event tallies; tests compare deltas
    always @(negedge clk) begin
        if (done) n_done++;
        if (error) n_err++;
        if (done && error) n_both++;
        if (done || error) last_busy = busy;
        if (ps2clk_oe && !ps2dat_oe) n_inh++;
        if (ps2clk_oe && ps2dat_oe) n_start++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Keyboard side: waits for request-to-send, clocks 11 pulses, samples
    // frame bits while the clock is low, optionally ACKs on pulse 11.
    // abort_at>0 returns with the clock held low right after that falling edge.
    task automatic dev_frame(input bit ack, input int abort_at,
                             output logic [10:0] cap, output bit ok);
        int t;
        cap = '0;
        ok  = 1'b0;
        t   = 0;
        while (!(ps2clk_line && !ps2dat_line) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        ok = 1'b1;
        cap[0] = ps2dat_line;
        for (int k = 1; k <= 11; k++) begin
            repeat (HALF) @(negedge clk);
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == abort_at) return;
            repeat (HALF) @(negedge clk);
            if (k <= 10) cap[k] = ps2dat_line;
            dev_clk_low = 1'b0;
        end
        repeat (2) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] d, input bit ack,
                           input bit exp_par, input int exp_done, input int exp_err);
        int bd, be, bi, bs;
        logic [10:0] cap;
        bit ok;
        bd = n_done; be = n_err; bi = n_inh; bs = n_start;
        start_tx(d);
        dev_frame(ack, 0, cap, ok);
        repeat (30) @(negedge clk);
        check($sformatf("%s rts_seen", tag), 32'(ok), 32'd1);
        check($sformatf("%s start_bit", tag), 32'(cap[0]), 32'd0);
        check($sformatf("%s data", tag), 32'(cap[8:1]), 32'(d));
        check($sformatf("%s parity", tag), 32'(cap[9]), 32'(exp_par));
        check($sformatf("%s stop", tag), 32'(cap[10]), 32'd1);
        check($sformatf("%s done_pulses", tag), 32'(n_done - bd), 32'(exp_done));
        check($sformatf("%s error_pulses", tag), 32'(n_err - be), 32'(exp_err));
        check($sformatf("%s inhibit_cycles", tag), 32'(n_inh - bi), 32'(INH));
        check($sformatf("%s start_cycles", tag), 32'(n_start - bs), 32'd1);
        check($sformatf("%s busy_at_pulse", tag), 32'(last_busy), 32'd0);
        check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bd, be, bi, t, n;
        logic [10:0] cap;
        bit ok;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b0, 1, 0};
        vecs[4] = '{8'hAA, 1'b0, 1'b1, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst ps2clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst ps2dat_oe", 32'(ps2dat_oe), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack,
                    vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);
        end

        // tx_start while busy is ignored, both during inhibit and mid-frame
        fork
            run_vec("busy_ff", 8'hFF, 1'b1, 1'b1, 1, 0);
            begin
                repeat (20) @(negedge clk);
                tx_data = 8'h55; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (250) @(negedge clk);
                tx_data = 8'h55; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0; tx_data = 8'h00;
            end
        join
        bi = n_inh;
        repeat (60) @(negedge clk);
        check("busy_ff no_restart", 32'(n_inh - bi), 32'd0);
        check("busy_ff idle", 32'(busy), 32'd0);

        // Device never clocks: error exactly TMO cycles after REQ entry
        bd = n_done; be = n_err;
        start_tx(8'hA5);
        t = 0;
        while (!(ps2clk_oe == 1'b0 && ps2dat_oe == 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tmo req_reached", 32'(t < 200), 32'd1);
        n = 0;
        while (!error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tmo latency", 32'(n), 32'(TMO));
        check("tmo ps2clk_oe", 32'(ps2clk_oe), 32'd0);
        check("tmo ps2dat_oe", 32'(ps2dat_oe), 32'd0);
        check("tmo busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("tmo error_pulses", 32'(n_err - be), 32'd1);
        check("tmo done_pulses", 32'(n_done - bd), 32'd0);

        // Reset at falling edge 5 of the data phase (bit 4 of 0x2C is 0)
        bd = n_done; be = n_err;
        start_tx(8'h2C);
        dev_frame(1'b1, 5, cap, ok);
        check("rstmid rts_seen", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        check("rstmid driving_bit4", 32'(ps2dat_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid ps2clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rstmid ps2dat_oe", 32'(ps2dat_oe), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid done_pulses", 32'(n_done - bd), 32'd0);
        check("rstmid error_pulses", 32'(n_err - be), 32'd0);
        run_vec("after_rst", 8'hF4, 1'b1, 1'b0, 1, 0);

        check("never_done_and_error", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
